// File: rtl/pc_gen_if.sv
// pc_gen_if: next-PC control and fetch-address bundle; the slave side is the PC generator.
// PC_GEN_COMPRESSED_EN adds the is_c_i step-size select.
interface pc_gen_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             stall_i;
    logic [1:0]       pcmux_i;
    logic [XLEN-1:0]  immb_i;
    logic [XLEN-1:0]  immj_i;
    logic [XLEN-1:0]  jt_i;
    logic             trap_req_i;
    logic [XLEN-1:0]  trap_vec_i;
    logic             mret_i;
    logic [XLEN-1:0]  mepc_i;
    logic             resume_i;
`ifdef PC_GEN_COMPRESSED_EN
    logic             is_c_i;
`endif
    logic [XLEN-1:0]  pc_o;
    logic [XLEN-1:0]  pc_plus4_o;
    logic             instr_valid_o;
    logic             misalign_o;
    logic             halted_o;
    logic [CNT_W-1:0] instr_count_o;

    modport slave (
        input  stall_i, pcmux_i, immb_i, immj_i, jt_i, trap_req_i, trap_vec_i,
               mret_i, mepc_i, resume_i,
`ifdef PC_GEN_COMPRESSED_EN
               is_c_i,
`endif
        output pc_o, pc_plus4_o, instr_valid_o, misalign_o, halted_o, instr_count_o
    );

    modport master (
        output stall_i, pcmux_i, immb_i, immj_i, jt_i, trap_req_i, trap_vec_i,
               mret_i, mepc_i, resume_i,
`ifdef PC_GEN_COMPRESSED_EN
               is_c_i,
`endif
        input  pc_o, pc_plus4_o, instr_valid_o, misalign_o, halted_o, instr_count_o
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: RISC-V program counter with stall, trap/mret redirect, misalign halt/resume and retire counter.
// PC_GEN_COMPRESSED_EN enables 2-byte sequential steps and 2-byte alignment.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              CNT_W        = 32
) (
    input  logic     clk,
    input  logic     reset,
    pc_gen_if.slave  bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mis_q, mis_d;
    logic [XLEN-1:0]  step, amask, pc_step, tgt, tvec, epc;
    logic             bad;

`ifdef PC_GEN_COMPRESSED_EN
    assign step  = bus.is_c_i ? XLEN'(2) : XLEN'(4);
    assign amask = ~XLEN'(1);
    assign bad   = tgt[0];
`else
    assign step  = XLEN'(4);
    assign amask = ~XLEN'(3);
    assign bad   = |tgt[1:0];
`endif

    assign pc_step = pc_q + step;
    assign tgt     = bus.pcmux_i == 2'b00 ? pc_step :
                     bus.pcmux_i == 2'b01 ? pc_q + bus.immb_i :
                     bus.pcmux_i == 2'b10 ? pc_q + bus.immj_i :
                                            bus.jt_i & ~XLEN'(1);
    assign tvec    = bus.trap_vec_i & amask;
    assign epc     = bus.mepc_i & amask;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        mis_d   = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (bus.trap_req_i) begin
                    pc_d  = tvec;
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (bus.mret_i) begin
                    pc_d  = epc;
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!bus.stall_i) begin
                    if (bad) begin
                        mis_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d  = tgt;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HALT: begin
                // the resume step skips the faulting instruction without retiring it
                if (bus.trap_req_i || bus.resume_i) begin
                    pc_d    = bus.trap_req_i ? tvec : pc_step;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.pc_plus4_o    = pc_step;
    assign bus.instr_valid_o = state_q == RUN && !bus.stall_i;
    assign bus.misalign_o    = mis_q;
    assign bus.halted_o      = state_q == HALT;
    assign bus.instr_count_o = cnt_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and random checks of pc_gen against a rule-level PC model (default build).
module tb_pc_gen;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    logic [31:0] m_pc, m_cnt;
    logic        m_mis;
    int          m_ph;

    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32), .CNT_W(32)) b ();
    pc_gen_if #(.XLEN(32), .CNT_W(32)) w ();

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(b));
    pc_gen #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC), .CNT_W(32)) dut_w (.clk(clk), .reset(reset), .bus(w));

    assign w.stall_i    = 1'b0;
    assign w.pcmux_i    = 2'b00;
    assign w.immb_i     = '0;
    assign w.immj_i     = '0;
    assign w.jt_i       = '0;
    assign w.trap_req_i = 1'b0;
    assign w.trap_vec_i = '0;
    assign w.mret_i     = 1'b0;
    assign w.mepc_i     = '0;
    assign w.resume_i   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        b.stall_i = 0; b.pcmux_i = 0; b.immb_i = 0; b.immj_i = 0; b.jt_i = 0;
        b.trap_req_i = 0; b.trap_vec_i = 0; b.mret_i = 0; b.mepc_i = 0; b.resume_i = 0;
    endtask

    // phases: 0 boot, 1 run, 2 halt
    task automatic tick();
        logic [31:0] npc, ncnt, t;
        logic        nmis;
        int          nph;
        npc = m_pc; ncnt = m_cnt; nmis = 0; nph = m_ph; t = 0;
        if (reset) begin
            npc = 0; ncnt = 0; nph = 0;
        end else if (m_ph == 0) begin
            nph = 1;
        end else if (m_ph == 1) begin
            if (b.trap_req_i) begin
                npc = b.trap_vec_i & ~32'd3; ncnt = ncnt + 1;
            end else if (b.mret_i) begin
                npc = b.mepc_i & ~32'd3; ncnt = ncnt + 1;
            end else if (!b.stall_i) begin
                case (b.pcmux_i)
                    2'd0: t = m_pc + 4;
                    2'd1: t = m_pc + b.immb_i;
                    2'd2: t = m_pc + b.immj_i;
                    default: t = b.jt_i & ~32'd1;
                endcase
                if (t % 4 != 0) begin
                    nmis = 1; nph = 2;
                end else begin
                    npc = t; ncnt = ncnt + 1;
                end
            end
        end else if (b.trap_req_i) begin
            npc = b.trap_vec_i & ~32'd3; nph = 1;
        end else if (b.resume_i) begin
            npc = m_pc + 4; nph = 1;
        end
        @(posedge clk);
        m_pc = npc; m_cnt = ncnt; m_mis = nmis; m_ph = nph;
        #1;
        chk("pc", b.pc_o, m_pc);
        chk("pc_plus4", b.pc_plus4_o, m_pc + 32'd4);
        chk("count", b.instr_count_o, m_cnt);
        chk("misalign", b.misalign_o, m_mis);
        chk("halted", b.halted_o, m_ph == 2);
        chk("valid", b.instr_valid_o, m_ph == 1 && !b.stall_i);
    endtask

    initial begin
        m_pc = 0; m_cnt = 0; m_mis = 0; m_ph = 0;
        idle();
        reset = 1;
        tick(); tick();
        chk("rst_pc", b.pc_o, 0);
        chk("wrap_rst_pc", w.pc_o, 32'hFFFF_FFFC);
        reset = 0;
        chk("boot_valid", b.instr_valid_o, 0);
        tick();
        chk("boot_pc", b.pc_o, 0);
        tick();
        chk("seq_pc4", b.pc_o, 4);
        chk("wrap_pc", w.pc_o, 0);
        tick(); tick();
        chk("seq_pc12", b.pc_o, 12);
        chk("seq_cnt", b.instr_count_o, 3);
        b.stall_i = 1;
        repeat (3) tick();
        chk("stall_pc", b.pc_o, 12);
        chk("stall_cnt", b.instr_count_o, 3);
        b.stall_i = 0;
        tick();
        chk("unstall_pc", b.pc_o, 16);
        b.pcmux_i = 1; b.immb_i = 16; tick();
        chk("branch", b.pc_o, 32);
        b.pcmux_i = 2; b.immj_i = 32; tick();
        chk("jal", b.pc_o, 64);
        b.pcmux_i = 3; b.jt_i = 45; tick();
        chk("jalr", b.pc_o, 44);
        b.pcmux_i = 1; b.immb_i = -32'sd44; tick();
        chk("branch_neg", b.pc_o, 0);
        b.immb_i = 6; tick();
        chk("mis_pulse", b.misalign_o, 1);
        chk("mis_pc", b.pc_o, 0);
        b.pcmux_i = 0; tick();
        chk("mis_drop", b.misalign_o, 0);
        chk("mis_halt", b.halted_o, 1);
        b.resume_i = 1; tick();
        chk("resume_pc", b.pc_o, 4);
        chk("resume_cnt", b.instr_count_o, 8);
        idle();
        b.trap_req_i = 1; b.trap_vec_i = 32'h100; b.stall_i = 1; b.mret_i = 1; tick();
        chk("trap_pc", b.pc_o, 32'h100);
        idle();
        b.mret_i = 1; b.mepc_i = 32'h43; tick();
        chk("mret_pc", b.pc_o, 32'h40);
        idle();
        b.pcmux_i = 3; b.jt_i = 32'h42; tick();
        chk("jalr_mis", b.halted_o, 1);
        idle();
        b.trap_req_i = 1; b.trap_vec_i = 32'h203; b.resume_i = 1; tick();
        chk("halt_trap_pc", b.pc_o, 32'h200);
        chk("halt_trap_run", b.halted_o, 0);
        idle();
        b.pcmux_i = 1; b.immb_i = 2; tick();
        reset = 1; tick();
        chk("rst_halt_pc", b.pc_o, 0);
        chk("rst_halt_h", b.halted_o, 0);
        reset = 0; idle(); tick();
        for (int i = 0; i < 3000; i++) begin
            reset        = $urandom_range(0, 199) == 0;
            b.stall_i    = $urandom_range(0, 4) == 0;
            b.pcmux_i    = 2'($urandom_range(0, 3));
            b.immb_i     = 32'($urandom_range(0, 31)) * 4 - 64 + ($urandom_range(0, 9) == 0 ? 32'($urandom_range(1, 3)) : 0);
            b.immj_i     = 32'($urandom_range(0, 255)) * 4 - 512 + ($urandom_range(0, 9) == 0 ? 32'd2 : 0);
            b.jt_i       = $urandom;
            b.trap_req_i = $urandom_range(0, 19) == 0;
            b.trap_vec_i = $urandom;
            b.mret_i     = $urandom_range(0, 19) == 0;
            b.mepc_i     = $urandom;
            b.resume_i   = $urandom_range(0, 1) == 0;
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
